alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised, handshaked successor to the 8-bit combinational ALU, and the next-generation execute unit for ProtoCore. Results and flags are registered, with a persistent carry flag for multi-word ADC/SBB chains. The opcode set grows to 4 bits: barrel shifts, arithmetic shift, rotate, compare, and an iterative shift-add multiplier. The block sits between decode and writeback, with valid/ready on both sides.

Parameters:
WIDTH, 8, operand/result width; power of two, >= 4.
SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:
clk  input  1  clock.
rst  input  1  reset.
in_valid  input  1  operation offered.
in_ready  output  1  operation accepted when in_valid & in_ready at posedge clk.
opcode  input  4  operation select.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
out_valid  output  1  result registers hold an undelivered result.
out_ready  input  1  consumer takes result when out_valid & out_ready.
out  output  WIDTH  result (MUL: low half).
out_hi  output  WIDTH  MUL high half; 0 for all other ops.
carry  output  1  carry/borrow flag of the delivered result.
zero  output  1  (out == 0), and for MUL also (out_hi == 0).
neg  output  1  out[WIDTH-1].
ovf  output  1  signed overflow for ADD/SUB/ADC/SBB/CMP; otherwise 0.

Behaviour:
- One clock domain. Reset is synchronous and active-high, using clk and rst.
- On reset: out_valid=0, out/out_hi/carry/zero/neg/ovf=0, internal c_flag=0, FSM=IDLE. A reset mid-MUL aborts the operation and produces no result.
- Opcodes (0-7 are bit-compatible with the 3-bit ALU):
  - 0 ADD: a+b; carry = carry-out.
  - 1 SUB: a-b; carry = borrow (a<b unsigned).
  - 2 AND, 3 OR, 4 XOR: carry=0.
  - 5 NOT: ~a; carry=0.
  - 6 SHL: a<<1; carry = a[W-1].
  - 7 SHR: a>>1; carry = a[0].
  - 8 ADC: a+b+c_flag.
  - 9 SBB: a-b-c_flag; carry = borrow.
  - 10 SLL: a << b[SHW-1:0].
  - 11 SRL: a >> b[SHW-1:0].
  - 12 SRA: arithmetic right shift by b[SHW-1:0].
  - For SLL/SRL/SRA: shift amount n=0 gives out=a, carry=0. For n>0, carry = last bit shifted out (SLL: a[W-n]; SRL/SRA: a[n-1]).
  - 13 ROL: rotate a left by 1; carry = a[W-1].
  - 14 CMP: flags computed as for SUB, out=a.
  - 15 MUL: unsigned a*b, giving {out_hi,out}; carry = (out_hi != 0).
- c_flag is loaded with the carry of every completed op, on the same edge the result registers load. Back-to-back ADC/SBB therefore see the previous op's carry.
- FSM states are IDLE, MUL, OUT:
  - in_ready = (state != MUL) && (!out_valid || out_ready).
  - Non-MUL op accepted at edge N: results and flags registered at N; out_valid=1 visible in cycle N+1 (latency 1). With out_ready held high, throughput is 1 op/cycle.
  - MUL accepted at edge N: FSM goes to MUL, a/b are latched, and one shift-add step runs per cycle for WIDTH steps. The result is registered and out_valid rises WIDTH cycles after acceptance. in_ready=0 throughout MUL.
  - OUT: out_valid=1. out and all flags stay stable until out_ready is sampled high.
  - If a result is taken and a new op accepted on the same edge, the new result replaces the old one; out_valid stays 1 for a non-MUL op and drops to 0 for a MUL op.
  - Backpressure: out_valid=1 with out_ready=0 forces in_ready=0. No result is ever overwritten or lost.
- in_valid=0 is never accepted. Inputs are sampled only on the accept edge, so a/b/opcode changes during MUL have no effect.
- Arithmetic is modulo 2^WIDTH.
- ovf = (sign a == sign b') && (sign result != sign a), where b' is b for add forms and ~b for subtract forms.

Test Plan:
1. WIDTH=8, ADD a=8'hFF b=8'h01, then ADC a=8'h00 b=8'h00 back-to-back, out_ready=1 -> results 8'h00 carry=1 zero=1, then 8'h01 carry=0 on consecutive cycles.
2. SUB a=8'h80 b=8'h01 -> out=8'h7F, ovf=1, carry=0, neg=0. CMP a=8'h05 b=8'h07 -> out=8'h05, carry=1, neg=1.
3. MUL a=8'hFF b=8'hFF -> in_ready=0 for 8 cycles; out_valid rises 8 cycles after accept with out_hi=8'hFE, out=8'h01, carry=1.
4. SRA a=8'h90 b=8'h03 -> out=8'hF2, carry=0. SLL a=8'h81 b=8'h08 (n=0) -> out=8'h81, carry=0.
5. Hold out_ready=0 after one ADD, keeping in_valid=1 -> in_ready=0, out/flags frozen. Raise out_ready -> next op accepted the same edge, with no result dropped.
6. Assert rst mid-MUL (cycle 4) -> next cycle out_valid=0, in_ready=1, c_flag=0. A following ADC 8'h01+8'h01 gives 8'h02.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: valid/ready execute unit with registered results and flags, a persistent
// carry for ADC/SBB chains, and an iterative shift-add multiplier.
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned W2  = 2 * WIDTH;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_ADC = 4'd8;
  localparam logic [3:0] OP_SBB = 4'd9;
  localparam logic [3:0] OP_SLL = 4'd10;
  localparam logic [3:0] OP_SRL = 4'd11;
  localparam logic [3:0] OP_SRA = 4'd12;
  localparam logic [3:0] OP_ROL = 4'd13;
  localparam logic [3:0] OP_CMP = 4'd14;
  localparam logic [3:0] OP_MUL = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_out_hi;
  logic             r_carry;
  logic             r_zero;
  logic             r_neg;
  logic             r_ovf;
  logic             r_c_flag;
  logic [W2-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [W2-1:0]    r_acc;
  logic [SHW-1:0]   r_cnt;

  state_t           w_state_nxt;
  logic             w_valid_nxt;
  logic [WIDTH-1:0] w_out_nxt;
  logic [WIDTH-1:0] w_hi_nxt;
  logic             w_carry_nxt;
  logic             w_zero_nxt;
  logic             w_neg_nxt;
  logic             w_ovf_nxt;
  logic             w_cflag_nxt;
  logic [W2-1:0]    w_mcand_nxt;
  logic [WIDTH-1:0] w_mplier_nxt;
  logic [W2-1:0]    w_acc_nxt;
  logic [SHW-1:0]   w_cnt_nxt;

  logic             w_accept;
  logic             w_take;
  logic             w_cin;
  logic             w_bin;
  logic [SHW-1:0]   w_sh;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH:0]   w_sll;
  logic [WIDTH:0]   w_srl;
  logic [WIDTH:0]   w_sra;
  logic [WIDTH-1:0] w_alu_res;
  logic [WIDTH-1:0] w_alu_out;
  logic             w_alu_carry;
  logic             w_alu_ovf;
  logic [W2-1:0]    w_acc_step;
  logic [WIDTH-1:0] w_mul_hi;

  assign in_ready = (r_state != S_MUL) && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_take   = r_out_valid && out_ready;

  // Carry chain: c_flag only feeds the operations that consume it
  assign w_cin = (opcode == OP_ADC) && r_c_flag;
  assign w_bin = (opcode == OP_SBB) && r_c_flag;
  assign w_sh  = b[SHW-1:0];

  // The extra bit in each wide result captures the carry/borrow or last bit shifted out
  assign w_add = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, w_cin};
  assign w_sub = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, w_bin};
  assign w_sll = {1'b0, a} << w_sh;
  assign w_srl = {a, 1'b0} >> w_sh;
  assign w_sra = $signed({a, 1'b0}) >>> w_sh;

  // Single-cycle operations; w_alu_res is the value the flags describe
  always_comb begin
    w_alu_res   = '0;
    w_alu_carry = 1'b0;
    w_alu_ovf   = 1'b0;
    case (opcode)
      OP_ADD, OP_ADC: begin
        w_alu_res   = w_add[WIDTH-1:0];
        w_alu_carry = w_add[WIDTH];
        w_alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        w_alu_res   = w_sub[WIDTH-1:0];
        w_alu_carry = w_sub[WIDTH];
        w_alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: w_alu_res = a & b;
      OP_OR:  w_alu_res = a | b;
      OP_XOR: w_alu_res = a ^ b;
      OP_NOT: w_alu_res = ~a;
      OP_SHL: begin
        w_alu_res   = {a[WIDTH-2:0], 1'b0};
        w_alu_carry = a[WIDTH-1];
      end
      OP_SHR: begin
        w_alu_res   = {1'b0, a[WIDTH-1:1]};
        w_alu_carry = a[0];
      end
      OP_SLL: begin
        w_alu_res   = w_sll[WIDTH-1:0];
        w_alu_carry = w_sll[WIDTH];
      end
      OP_SRL: begin
        w_alu_res   = w_srl[WIDTH:1];
        w_alu_carry = w_srl[0];
      end
      OP_SRA: begin
        w_alu_res   = w_sra[WIDTH:1];
        w_alu_carry = w_sra[0];
      end
      OP_ROL: begin
        w_alu_res   = {a[WIDTH-2:0], a[WIDTH-1]};
        w_alu_carry = a[WIDTH-1];
      end
      default: ;
    endcase
  end

  // CMP reports subtraction flags but passes A through
  assign w_alu_out = (opcode == OP_CMP) ? a : w_alu_res;

  assign w_acc_step = r_acc + (r_mplier[0] ? r_mcand : {W2{1'b0}});
  assign w_mul_hi   = w_acc_step[W2-1:WIDTH];

  // Next-state and result-register update
  always_comb begin
    w_state_nxt  = r_state;
    w_valid_nxt  = r_out_valid;
    w_out_nxt    = r_out;
    w_hi_nxt     = r_out_hi;
    w_carry_nxt  = r_carry;
    w_zero_nxt   = r_zero;
    w_neg_nxt    = r_neg;
    w_ovf_nxt    = r_ovf;
    w_cflag_nxt  = r_c_flag;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_acc_nxt    = r_acc;
    w_cnt_nxt    = r_cnt;
    case (r_state)
      S_MUL: begin
        w_mcand_nxt  = r_mcand << 1;
        w_mplier_nxt = r_mplier >> 1;
        w_acc_nxt    = w_acc_step;
        w_cnt_nxt    = r_cnt + SHW'(1);
        if (r_cnt == SHW'(WIDTH - 1)) begin
          w_state_nxt = S_OUT;
          w_valid_nxt = 1'b1;
          w_out_nxt   = w_acc_step[WIDTH-1:0];
          w_hi_nxt    = w_mul_hi;
          w_carry_nxt = |w_mul_hi;
          w_zero_nxt  = (w_acc_step == {W2{1'b0}});
          w_neg_nxt   = w_acc_step[WIDTH-1];
          w_ovf_nxt   = 1'b0;
          w_cflag_nxt = |w_mul_hi;
        end
      end
      default: begin
        if (w_accept) begin
          if (opcode == OP_MUL) begin
            w_state_nxt  = S_MUL;
            w_valid_nxt  = 1'b0;
            w_mcand_nxt  = {{WIDTH{1'b0}}, a};
            w_mplier_nxt = b;
            w_acc_nxt    = '0;
            w_cnt_nxt    = '0;
          end else begin
            w_state_nxt = S_OUT;
            w_valid_nxt = 1'b1;
            w_out_nxt   = w_alu_out;
            w_hi_nxt    = '0;
            w_carry_nxt = w_alu_carry;
            w_zero_nxt  = (w_alu_res == {WIDTH{1'b0}});
            w_neg_nxt   = w_alu_res[WIDTH-1];
            w_ovf_nxt   = w_alu_ovf;
            w_cflag_nxt = w_alu_carry;
          end
        end else if (w_take) begin
          w_state_nxt = S_IDLE;
          w_valid_nxt = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_out_hi    <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_ovf       <= 1'b0;
      r_c_flag    <= 1'b0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= w_valid_nxt;
      r_out       <= w_out_nxt;
      r_out_hi    <= w_hi_nxt;
      r_carry     <= w_carry_nxt;
      r_zero      <= w_zero_nxt;
      r_neg       <= w_neg_nxt;
      r_ovf       <= w_ovf_nxt;
      r_c_flag    <= w_cflag_nxt;
      r_mcand     <= w_mcand_nxt;
      r_mplier    <= w_mplier_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign out_hi    = r_out_hi;
  assign carry     = r_carry;
  assign zero      = r_zero;
  assign neg       = r_neg;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed scenarios plus a randomized run against an arithmetic reference model.
module tb_alu_seq;

  localparam int unsigned W = 8;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_ADC = 4'd8;
  localparam logic [3:0] OP_SLL = 4'd10;
  localparam logic [3:0] OP_SRL = 4'd11;
  localparam logic [3:0] OP_SRA = 4'd12;
  localparam logic [3:0] OP_ROL = 4'd13;
  localparam logic [3:0] OP_CMP = 4'd14;
  localparam logic [3:0] OP_MUL = 4'd15;

  typedef struct packed {
    logic [7:0] lo;
    logic [7:0] hi;
    logic       c;
    logic       z;
    logic       n;
    logic       v;
  } res_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] opcode = 4'd0;
  logic [7:0] a = 8'd0;
  logic [7:0] b = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out;
  logic [7:0] out_hi;
  logic       carry, zero, neg, ovf;

  int checks = 0;
  int errors = 0;

  logic s_in_ready;
  logic s_valid;
  res_t s_obs;

  // reference-model state
  logic m_valid;
  logic m_cflag;
  int   m_mul_left;
  res_t m_cur;
  res_t m_pend;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_hi(out_hi), .carry(carry), .zero(zero), .neg(neg), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic res_t obs();
    return {out, out_hi, carry, zero, neg, ovf};
  endfunction

  // Plain integer arithmetic on the operation definitions
  function automatic res_t ref_op(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y,
                                  input logic cin);
    int ua, ub, sa, sb, r, sr, n, ci, p;
    logic [7:0] f;
    res_t e;
    e = '0;
    ua = int'(x);
    ub = int'(y);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    n  = ub % 8;
    ci = cin ? 1 : 0;
    f  = 8'd0;
    case (op)
      4'd0, 4'd8: begin
        if (op == 4'd0) ci = 0;
        r   = ua + ub + ci;
        sr  = sa + sb + ci;
        f   = 8'(r);
        e.c = (r > 255);
        e.v = (sr > 127) || (sr < -128);
      end
      4'd1, 4'd9, 4'd14: begin
        if (op != 4'd9) ci = 0;
        r   = ua - ub - ci;
        sr  = sa - sb - ci;
        f   = 8'(r);
        e.c = (r < 0);
        e.v = (sr > 127) || (sr < -128);
      end
      4'd2: f = x & y;
      4'd3: f = x | y;
      4'd4: f = x ^ y;
      4'd5: f = ~x;
      4'd6: begin f = 8'(ua * 2); e.c = (ua >= 128); end
      4'd7: begin f = 8'(ua / 2); e.c = (ua % 2 == 1); end
      4'd10: begin
        f   = 8'(ua << n);
        e.c = (n == 0) ? 1'b0 : (((ua >> (8 - n)) % 2) == 1);
      end
      4'd11: begin
        f   = 8'(ua >> n);
        e.c = (n == 0) ? 1'b0 : (((ua >> (n - 1)) % 2) == 1);
      end
      4'd12: begin
        f   = 8'(sa >>> n);
        e.c = (n == 0) ? 1'b0 : (((ua >> (n - 1)) % 2) == 1);
      end
      4'd13: begin f = 8'(ua * 2 + ua / 128); e.c = (ua >= 128); end
      default: ;
    endcase
    if (op == 4'd15) begin
      p    = ua * ub;
      e.lo = 8'(p);
      e.hi = 8'(p / 256);
      e.c  = (p >= 256);
      e.z  = (p == 0);
      e.n  = e.lo[7];
    end else begin
      e.lo = (op == 4'd14) ? x : f;
      e.z  = (f == 8'd0);
      e.n  = f[7];
    end
    return e;
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One clock: drive inputs, sample the pre-edge view, then step past the edge
  task automatic drive(input logic v, input logic [3:0] op, input logic [7:0] x,
                       input logic [7:0] y, input logic ordy);
    in_valid  = v;
    opcode    = op;
    a         = x;
    b         = y;
    out_ready = ordy;
    #1;
    s_in_ready = in_ready;
    s_valid    = out_valid;
    s_obs      = obs();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    out_ready = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++;
    if (obs() !== res_t'(0)) begin errors++; $display("FAIL reset_outputs got %h exp 0", obs()); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_add_adc();
    apply_reset();
    drive(1'b1, OP_ADD, 8'hFF, 8'h01, 1'b1);
    checks++;
    if (s_in_ready !== 1'b1) begin errors++; $display("FAIL add_accept got %b exp 1", s_in_ready); end
    checks++;
    if ({out_valid, out, carry, zero} !== {1'b1, 8'h00, 1'b1, 1'b1})
      begin errors++; $display("FAIL add_result got v%b %h c%b z%b exp v1 00 c1 z1", out_valid, out, carry, zero); end
    drive(1'b1, OP_ADC, 8'h00, 8'h00, 1'b1);
    checks++;
    if (s_in_ready !== 1'b1) begin errors++; $display("FAIL adc_b2b_accept got %b exp 1", s_in_ready); end
    checks++;
    if ({out_valid, out, carry, zero} !== {1'b1, 8'h01, 1'b0, 1'b0})
      begin errors++; $display("FAIL adc_result got v%b %h c%b z%b exp v1 01 c0 z0", out_valid, out, carry, zero); end
    drive(1'b0, OP_ADD, 8'h00, 8'h00, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_sub_cmp();
    apply_reset();
    drive(1'b1, OP_SUB, 8'h80, 8'h01, 1'b1);
    checks++;
    if ({out, ovf, carry, neg} !== {8'h7F, 1'b1, 1'b0, 1'b0})
      begin errors++; $display("FAIL sub_ovf got %h v%b c%b n%b exp 7f v1 c0 n0", out, ovf, carry, neg); end
    drive(1'b1, OP_CMP, 8'h05, 8'h07, 1'b1);
    checks++;
    if ({out, carry, neg, zero, ovf} !== {8'h05, 1'b1, 1'b1, 1'b0, 1'b0})
      begin errors++; $display("FAIL cmp got %h c%b n%b z%b v%b exp 05 c1 n1 z0 v0", out, carry, neg, zero, ovf); end
    drive(1'b0, OP_ADD, 8'h00, 8'h00, 1'b1);
  endtask

  task automatic test_mul();
    int busy_bad;
    apply_reset();
    busy_bad = 0;
    drive(1'b1, OP_MUL, 8'hFF, 8'hFF, 1'b1);
    checks++;
    if (s_in_ready !== 1'b1) begin errors++; $display("FAIL mul_accept got %b exp 1", s_in_ready); end
    for (int i = 0; i < 8; i++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b0) busy_bad++;
      drive(1'b1, OP_ADD, 8'($urandom), 8'($urandom), 1'b1);
    end
    checks++;
    if (busy_bad != 0) begin errors++; $display("FAIL mul_busy got %0d bad cycles exp 0", busy_bad); end
    checks++;
    if ({out_valid, out_hi, out, carry, zero} !== {1'b1, 8'hFE, 8'h01, 1'b1, 1'b0})
      begin errors++; $display("FAIL mul_result got v%b %h%h c%b z%b exp v1 fe01 c1 z0", out_valid, out_hi, out, carry, zero); end
    // MUL carry feeds the next ADC
    drive(1'b1, OP_ADC, 8'h00, 8'h00, 1'b1);
    checks++;
    if ({out_valid, out, out_hi} !== {1'b1, 8'h01, 8'h00})
      begin errors++; $display("FAIL mul_then_adc got v%b %h hi %h exp v1 01 hi 00", out_valid, out, out_hi); end
    drive(1'b0, OP_ADD, 8'h00, 8'h00, 1'b1);
  endtask

  task automatic test_shifts();
    apply_reset();
    drive(1'b1, OP_SRA, 8'h90, 8'h03, 1'b1);
    checks++;
    if ({out, carry} !== {8'hF2, 1'b0}) begin errors++; $display("FAIL sra got %h c%b exp f2 c0", out, carry); end
    drive(1'b1, OP_SLL, 8'h81, 8'h08, 1'b1);
    checks++;
    if ({out, carry} !== {8'h81, 1'b0}) begin errors++; $display("FAIL sll_n0 got %h c%b exp 81 c0", out, carry); end
    drive(1'b1, OP_SRL, 8'h81, 8'h01, 1'b1);
    checks++;
    if ({out, carry} !== {8'h40, 1'b1}) begin errors++; $display("FAIL srl got %h c%b exp 40 c1", out, carry); end
    drive(1'b1, OP_SLL, 8'h81, 8'h07, 1'b1);
    checks++;
    if ({out, carry} !== {8'h80, 1'b0}) begin errors++; $display("FAIL sll_n7 got %h c%b exp 80 c0", out, carry); end
    drive(1'b1, OP_ROL, 8'h81, 8'h00, 1'b1);
    checks++;
    if ({out, carry} !== {8'h03, 1'b1}) begin errors++; $display("FAIL rol got %h c%b exp 03 c1", out, carry); end
    drive(1'b0, OP_ADD, 8'h00, 8'h00, 1'b1);
  endtask

  task automatic test_backpressure();
    res_t held;
    int   bad;
    apply_reset();
    bad = 0;
    drive(1'b1, OP_ADD, 8'h12, 8'h34, 1'b0);
    held = obs();
    checks++;
    if ({out_valid, out} !== {1'b1, 8'h46}) begin errors++; $display("FAIL bp_first got v%b %h exp v1 46", out_valid, out); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, OP_XOR, 8'($urandom), 8'($urandom), 1'b0);
      if (s_in_ready !== 1'b0 || out_valid !== 1'b1 || obs() !== held) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_hold got %0d bad cycles exp 0", bad); end
    drive(1'b1, OP_SUB, 8'h50, 8'h10, 1'b1);
    checks++;
    if (s_in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_accept got %b exp 1", s_in_ready); end
    checks++;
    if ({out_valid, out} !== {1'b1, 8'h40}) begin errors++; $display("FAIL bp_next got v%b %h exp v1 40", out_valid, out); end
    drive(1'b0, OP_ADD, 8'h00, 8'h00, 1'b1);
  endtask

  task automatic test_reset_mid_mul();
    int late;
    apply_reset();
    late = 0;
    drive(1'b1, OP_ADD, 8'hFF, 8'h01, 1'b1);
    drive(1'b1, OP_MUL, 8'h0F, 8'h0F, 1'b1);
    repeat (3) drive(1'b0, OP_ADD, 8'h00, 8'h00, 1'b1);
    rst = 1'b1;
    drive(1'b0, OP_ADD, 8'h00, 8'h00, 1'b1);
    rst = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== {1'b0, 1'b1})
      begin errors++; $display("FAIL mid_mul_reset got v%b rdy%b exp v0 rdy1", out_valid, in_ready); end
    drive(1'b1, OP_ADC, 8'h01, 8'h01, 1'b1);
    checks++;
    if ({out_valid, out, carry} !== {1'b1, 8'h02, 1'b0})
      begin errors++; $display("FAIL adc_after_reset got v%b %h c%b exp v1 02 c0", out_valid, out, carry); end
    drive(1'b0, OP_ADD, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, OP_ADD, 8'h00, 8'h00, 1'b1);
      if (out_valid !== 1'b0) late++;
    end
    checks++;
    if (late != 0) begin errors++; $display("FAIL aborted_mul_result got %0d valid cycles exp 0", late); end
  endtask

  task automatic test_random();
    logic       v, ordy, exp_ready, acc;
    logic [3:0] op;
    logic [7:0] x, y;
    res_t       r;
    apply_reset();
    m_valid    = 1'b0;
    m_cflag    = 1'b0;
    m_mul_left = 0;
    m_cur      = '0;
    m_pend     = '0;
    for (int i = 0; i < 600; i++) begin
      v    = ($urandom_range(0, 3) != 0);
      op   = 4'($urandom_range(0, 15));
      x    = 8'($urandom);
      y    = 8'($urandom);
      ordy = ($urandom_range(0, 9) < 7);
      exp_ready = (m_mul_left == 0) && (!m_valid || ordy);
      drive(v, op, x, y, ordy);
      checks++;
      if (s_valid !== m_valid) begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", i, s_valid, m_valid); end
      checks++;
      if (s_in_ready !== exp_ready) begin errors++; $display("FAIL rnd_in_ready cyc %0d got %b exp %b", i, s_in_ready, exp_ready); end
      if (m_valid) begin
        checks++;
        if (s_obs !== m_cur) begin errors++; $display("FAIL rnd_result cyc %0d got %h exp %h", i, s_obs, m_cur); end
      end
      acc = v && exp_ready;
      if (m_valid && ordy) m_valid = 1'b0;
      if (m_mul_left > 0) begin
        m_mul_left--;
        if (m_mul_left == 0) begin
          m_valid = 1'b1;
          m_cur   = m_pend;
        end
      end
      if (acc) begin
        r       = ref_op(op, x, y, m_cflag);
        m_cflag = r.c;
        if (op == OP_MUL) begin
          m_mul_left = W;
          m_pend     = r;
        end else begin
          m_valid = 1'b1;
          m_cur   = r;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_adc();
    test_sub_cmp();
    test_mul();
    test_shifts();
    test_backpressure();
    test_reset_mid_mul();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
